// File: rtl/framebuf_writer_if.sv
// Pixel-stream, blanking and framebuffer write-port bundle for framebuf_writer.
// master is the capture/display side, slave is the writer.
interface framebuf_writer_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_sof;
  logic                  pix_ready;
  logic                  vblank;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] rd_base;
  logic                  frame_done;
  logic                  overrun;
  logic [7:0]            drop_count;

  modport master (
    output pix_data, pix_valid, pix_sof, vblank,
    input  pix_ready, wr_en, wr_addr, wr_data, rd_bank, rd_base, frame_done, overrun, drop_count
  );

  modport slave (
    input  pix_data, pix_valid, pix_sof, vblank,
    output pix_ready, wr_en, wr_addr, wr_data, rd_bank, rd_base, frame_done, overrun, drop_count
  );
endinterface

// File: rtl/framebuf_writer.sv
// Writes complete frames into the non-displayed half of a dual-bank framebuffer and
// flips the displayed bank only during vertical blanking.
module framebuf_writer #(
  parameter int unsigned FRAME_WIDTH  = 176,
  parameter int unsigned FRAME_HEIGHT = 144,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic              clk_25,
  input  logic              reset_n,
  framebuf_writer_if.slave  bus
);
  localparam int unsigned N     = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int unsigned OFF_W = $clog2(N);
  localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(N);
  localparam logic [OFF_W-1:0]      LAST_OFF   = OFF_W'(N - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StPending} state_e;

  state_e                r_state;
  logic [OFF_W-1:0]      r_offset;
  logic                  r_rd_bank;
  logic [ADDR_WIDTH-1:0] r_rd_base;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_frame_done;
  logic                  r_overrun;
  logic [7:0]            r_drop_count;

  logic                  w_xfer;
  logic                  w_sof_xfer;
  logic [ADDR_WIDTH-1:0] w_wbase;

  assign w_xfer     = bus.pix_valid & reset_n;
  assign w_sof_xfer = w_xfer & bus.pix_sof;
  // Write bank is always the one not being displayed.
  assign w_wbase    = r_rd_bank ? '0 : BANK1_BASE;

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_offset     <= '0;
      r_rd_bank    <= 1'b0;
      r_rd_base    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_sof_xfer) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_wbase;
            r_wr_data <= bus.pix_data;
            r_offset  <= OFF_W'(1);
            r_state   <= StWrite;
          end
        end
        StWrite: begin
          if (w_sof_xfer) begin
            // Short frame: restart at offset 0 over the partial data.
            r_overrun <= 1'b1;
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_wbase;
            r_wr_data <= bus.pix_data;
            r_offset  <= OFF_W'(1);
          end else if (w_xfer) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_wbase + ADDR_WIDTH'(r_offset);
            r_wr_data <= bus.pix_data;
            if (r_offset == LAST_OFF) begin
              r_frame_done <= 1'b1;
              r_offset     <= '0;
              r_state      <= StPending;
            end else begin
              r_offset <= r_offset + OFF_W'(1);
            end
          end
        end
        StPending: begin
          if (bus.vblank) begin
            r_rd_bank <= ~r_rd_bank;
            r_rd_base <= w_wbase;
            if (w_sof_xfer) begin
              // New write bank is the old read bank, whose base is r_rd_base.
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_rd_base;
              r_wr_data <= bus.pix_data;
              r_offset  <= OFF_W'(1);
              r_state   <= StWrite;
            end else begin
              r_state <= StIdle;
            end
          end else if (w_sof_xfer && r_drop_count != 8'hFF) begin
            r_drop_count <= r_drop_count + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.pix_ready  = reset_n;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.rd_bank    = r_rd_bank;
  assign bus.rd_base    = r_rd_base;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;
  assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_framebuf_writer.sv
// Bench for framebuf_writer: frame-level reference model compared every cycle, plus
// literal expectations at the key points of each scenario.
module tb_framebuf_writer;
  localparam int N = 176 * 144;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  framebuf_writer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  framebuf_writer #(
    .FRAME_WIDTH(176), .FRAME_HEIGHT(144), .ADDR_WIDTH(16), .DATA_WIDTH(8)
  ) dut (
    .clk_25 (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: frame progress as plain integers.
  bit         armed = 1'b0;
  bit         m_bank, m_busy, m_pend, m_ovr;
  int         m_idx, m_drop;
  bit         exp_wr_en, exp_done;
  int         exp_addr;
  logic [7:0] exp_data;
  bit         xfer, sof;
  int         done_cnt = 0;
  int         done_addr = -1;

  task automatic m_write(int i);
    exp_wr_en = 1'b1;
    exp_addr  = (m_bank ? 0 : N) + i;
    exp_data  = bus.pix_data;
  endtask

  task automatic m_start();
    m_write(0);
    m_busy = 1'b1;
    m_idx  = 1;
  endtask

  always @(posedge clk) begin
    exp_wr_en = 1'b0;
    exp_done  = 1'b0;
    if (!reset_n) begin
      armed = 1'b1; m_bank = 1'b0; m_busy = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
      m_idx = 0; m_drop = 0; exp_addr = 0; exp_data = 8'h00;
    end else if (armed) begin
      xfer = bus.pix_valid;
      sof  = xfer && bus.pix_sof;
      if (m_pend) begin
        if (bus.vblank) begin
          m_bank = !m_bank;
          m_pend = 1'b0;
          if (sof) m_start();
        end else if (sof && m_drop < 255) begin
          m_drop++;
        end
      end else if (sof) begin
        if (m_busy) m_ovr = 1'b1;
        m_start();
      end else if (xfer && m_busy) begin
        m_write(m_idx);
        m_idx++;
        if (m_idx == N) begin
          exp_done = 1'b1; m_busy = 1'b0; m_pend = 1'b1; m_idx = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (bus.pix_ready !== reset_n || bus.wr_en !== exp_wr_en
          || (exp_wr_en && (bus.wr_addr !== 16'(exp_addr) || bus.wr_data !== exp_data))
          || bus.frame_done !== exp_done || bus.rd_bank !== m_bank
          || bus.rd_base !== (m_bank ? 16'(N) : 16'd0) || bus.overrun !== m_ovr
          || bus.drop_count !== 8'(m_drop)) begin
        failures++;
        $display("FAIL model t=%0t: got en=%b addr=%0d data=%0d done=%b bank=%b base=%0d ovr=%b drop=%0d rdy=%b; expected en=%b addr=%0d data=%0d done=%b bank=%b ovr=%b drop=%0d rdy=%b",
                 $time, bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.rd_bank,
                 bus.rd_base, bus.overrun, bus.drop_count, bus.pix_ready, exp_wr_en, exp_addr,
                 exp_data, exp_done, m_bank, m_ovr, m_drop, reset_n);
      end
      if (bus.frame_done === 1'b1) begin
        done_cnt++;
        done_addr = int'(bus.wr_addr);
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs for one clock; returns 1 time unit after the sampling edge.
  task automatic cyc(bit v, bit s, logic [7:0] d, bit vb);
    bus.pix_valid = v;
    bus.pix_sof   = s;
    bus.pix_data  = d;
    bus.vblank    = vb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  sent;
    bit  v;
    reset_n       = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = 8'h00;
    bus.vblank    = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) cyc(1'b1, 1'($urandom % 2), 8'($urandom), 1'b0);
    check("rst_ready", 32'(bus.pix_ready), 0);
    check("rst_wr_en", 32'(bus.wr_en), 0);
    check("rst_wr_addr", 32'(bus.wr_addr), 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);
    check("rst_rd_bank", 32'(bus.rd_bank), 0);
    check("rst_rd_base", 32'(bus.rd_base), 0);
    check("rst_drop", 32'(bus.drop_count), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    reset_n = 1'b1;

    // Contiguous full frame into bank 1.
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, i == 0, 8'(i), 1'b0);
      if (i == 0) check("a_first_addr", 32'(bus.wr_addr), 25344);
    end
    check("a_done", 32'(bus.frame_done), 1);
    check("a_last_addr", 32'(bus.wr_addr), 50687);
    check("a_last_data", 32'(bus.wr_data), 255);

    // Frames arriving while pending are dropped.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 8'($urandom), 1'b0);
      repeat (5) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    end
    cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    check("drop_three", 32'(bus.drop_count), 3);
    check("drop_no_write", 32'(bus.wr_en), 0);

    // Swap and sof on the same edge.
    cyc(1'b1, 1'b1, 8'hAB, 1'b1);
    check("sim_rd_bank", 32'(bus.rd_bank), 1);
    check("sim_rd_base", 32'(bus.rd_base), 25344);
    check("sim_wr_en", 32'(bus.wr_en), 1);
    check("sim_wr_addr", 32'(bus.wr_addr), 0);
    check("sim_wr_data", 32'(bus.wr_data), 32'h0000_00AB);
    check("sim_drop_same", 32'(bus.drop_count), 3);

    // Short frame, then a gapped full frame with noisy vblank.
    for (int i = 1; i < 100; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'($urandom % 2));
    cyc(1'b1, 1'b1, 8'($urandom), 1'($urandom % 2));
    check("short_overrun", 32'(bus.overrun), 1);
    check("short_restart_addr", 32'(bus.wr_addr), 0);
    sent = 1;
    while (sent < N) begin
      v = ($urandom % 4) != 0;
      cyc(v, v ? 1'b0 : 1'($urandom % 2), 8'($urandom), 1'($urandom % 2));
      if (v) sent++;
    end
    check("b_done", 32'(bus.frame_done), 1);
    check("b_last_addr", 32'(bus.wr_addr), 25343);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("done_pulses", 32'(done_cnt), 2);
    check("done_addr_seen", 32'(done_addr), 25343);

    // Drop counter saturation.
    repeat (257) cyc(1'b1, 1'b1, 8'($urandom), 1'b0);
    check("drop_sat", 32'(bus.drop_count), 255);

    // Plain swap in blanking, then the next frame goes to bank 1.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("swap_rd_bank", 32'(bus.rd_bank), 0);
    check("swap_rd_base", 32'(bus.rd_base), 0);
    cyc(1'b1, 1'b1, 8'h5A, 1'b0);
    check("c_first_addr", 32'(bus.wr_addr), 25344);
    check("c_first_data", 32'(bus.wr_data), 32'h0000_005A);
    cyc(1'b1, 1'b0, 8'h11, 1'b0);
    check("c_second_addr", 32'(bus.wr_addr), 25345);

    // Reset mid-frame discards progress.
    reset_n = 1'b0;
    cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    check("mid_rst_wr_en", 32'(bus.wr_en), 0);
    check("mid_rst_drop", 32'(bus.drop_count), 0);
    check("mid_rst_overrun", 32'(bus.overrun), 0);
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    check("post_rst_nosof", 32'(bus.wr_en), 0);
    cyc(1'b1, 1'b1, 8'($urandom), 1'b0);
    check("post_rst_addr", 32'(bus.wr_addr), 25344);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/framebuf_writer.md
Name: framebuf_writer

Overview:
- Upstream neighbour of the VGA output stage. Accepts an 8-bit raw pixel stream from the capture path and writes complete 176x144 frames into a dual-bank framebuffer BRAM through its write port.
- Flips the displayed bank only during vertical blanking. The display side therefore never reads a partially written frame.
- Frames that arrive while a bank swap is still pending are dropped and counted.

Parameters:
FRAME_WIDTH, 176, pixels per line
FRAME_HEIGHT, 144, lines per frame
ADDR_WIDTH, 16, BRAM address width; must hold 2*FRAME_WIDTH*FRAME_HEIGHT
DATA_WIDTH, 8, pixel width

Ports:
clk_25  input  1  pixel/system clock, 25 MHz; single clock domain
reset_n  input  1  synchronous reset, active low
pix_data  input  DATA_WIDTH  incoming pixel value
pix_valid  input  1  pix_data valid this cycle
pix_sof  input  1  qualifies the first pixel of a frame (valid only with pix_valid)
pix_ready  output  1  block accepts a pixel; 0 while reset_n low, 1 otherwise
vblank  input  1  high while the display is in vertical blanking
wr_en  output  1  BRAM write strobe
wr_addr  output  ADDR_WIDTH  BRAM write address
wr_data  output  DATA_WIDTH  BRAM write data
rd_bank  output  1  bank the display must read
rd_base  output  ADDR_WIDTH  base address of rd_bank (0 or FRAME_WIDTH*FRAME_HEIGHT)
frame_done  output  1  one-cycle pulse when the last pixel of a frame is written
overrun  output  1  sticky flag: a SOF arrived before the frame completed
drop_count  output  8  saturating count of frames dropped in PENDING

Behaviour:
- One clock and one reset. Reset is synchronous and active-low: sampled on posedge clk_25 while reset_n=0.
- Reset values:
  - state=IDLE, offset=0, rd_bank=0, rd_base=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - frame_done=0, overrun=0, drop_count=0.
- Reset mid-frame discards all progress; no write issues on the reset cycle.
- Constants:
  - N = FRAME_WIDTH*FRAME_HEIGHT (25344).
  - Write bank = ~rd_bank.
  - wbase = 0 if rd_bank=1, N if rd_bank=0.
- Transfer = pix_valid & pix_ready.
- Address generation uses a running offset counter (0..N-1). No multiplier.
- wr_addr = wbase + offset, computed to ADDR_WIDTH bits.
- Write latency: wr_en, wr_addr and wr_data are registered and appear 1 cycle after the accepting edge.
- wr_en=0 on every cycle without an accepted write.
- State IDLE:
  - Transfer without sof: dropped, no write.
  - Transfer with sof: write at wbase+0, offset<=1, go to WRITE.
- State WRITE:
  - Transfer without sof: write at wbase+offset, offset<=offset+1.
  - If that write uses offset=N-1: frame_done=1 in the same cycle as that wr_en, offset<=0, go to PENDING.
  - Transfer with sof (short frame): overrun<=1 (sticky until reset). Write at wbase+0, offset<=1, stay in WRITE. The partial frame is overwritten.
  - No transfer: hold all state.
- State PENDING (a full frame is waiting for display):
  - vblank=1: rd_bank<=~rd_bank, rd_base updates in the same edge, go to IDLE.
  - vblank=0 and a sof transfer: drop_count<=drop_count+1, saturating at 255. No write.
  - Non-sof transfers are ignored.
  - vblank=1 together with a sof transfer on the same edge: swap occurs, and the pixel is written at offset 0 of the new write bank (the old read bank). offset<=1, go to WRITE. drop_count is not incremented.
- A sof arriving in the same cycle as the N-1 completion is impossible; pix_sof marks pixel 0 only.
- pix_sof without pix_valid is ignored.
- rd_bank/rd_base change only on the PENDING-to-swap edge, so they are stable for an entire display frame.

Test Plan:
- Reset check: hold reset_n=0 for 3 cycles with pix_valid=1 → pix_ready=0, wr_en=0, rd_bank=0, rd_base=0, drop_count=0, overrun=0.
- Full frame: sof + 25344 contiguous pixels (data=offset[7:0]), vblank=0 → wr_addr 25344..50687 in order, one cycle after each pixel. frame_done pulses with wr_addr=50687. Then raise vblank → rd_bank=1, rd_base=25344. The next frame writes 0..25343.
- Gapped stream: same frame with pix_valid toggling 1/0 → identical address/data sequence; wr_en=0 on gap cycles.
- Short frame: sof, 99 pixels, then sof again → overrun=1. Next write at wr_addr=25344 (offset 0). After 25344 further pixels, frame_done pulses once.
- Dropped frames: after frame_done keep vblank=0 and send 3 sof frames → no writes, drop_count=3. Force 260 sof frames → drop_count saturates at 255.
- Simultaneous swap: in PENDING, assert vblank and a sof transfer on the same edge → rd_bank toggles and the pixel is written to offset 0 of the new write bank. drop_count is unchanged; state continues in WRITE.
